deal_sequencer: RTL and testbench

- Round controller for one BlackJack hand.
- Sits on the requesting side of the 2-second timer handshake. It clears the timer, enables it, and waits for the elapsed pulse between dealt cards.
- Requests cards from the card source and accumulates player and dealer sums with soft-ace handling.
- Decides the round result and hands sums and result to the display logic.

---
 rtl/deal_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_deal_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deal_sequencer.sv
// deal_sequencer: round controller for one BlackJack hand.
// Paces dealt cards with the 2 s timer, tracks soft sums, decides the result.
module deal_sequencer #(
  parameter int DEALER_STAND = 17,
  parameter int SUM_W        = 5
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic             i_Start,
  input  logic             i_Hit,
  input  logic             i_Stay,
  input  logic             i_TwoSec,
  input  logic             i_CardValid,
  input  logic [3:0]       i_Card,
  output logic             o_Zero,
  output logic             o_ActiveCounter,
  output logic             o_CardReq,
  output logic [SUM_W-1:0] o_PlayerSum,
  output logic [SUM_W-1:0] o_DealerSum,
  output logic [1:0]       o_Result,
  output logic             o_Busy,
  output logic             o_Done
);

  localparam int IW = SUM_W + 1;
  localparam logic [IW-1:0] BJ    = IW'(21);
  localparam logic [IW-1:0] STAND = IW'(DEALER_STAND);

  typedef enum logic [3:0] {
    IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2,
    PLAYER, DEALER, WAIT_CLR, WAIT_RUN, RESULT, DONE
  } state_t;

  state_t state, ret_state, deal_ret;

  logic [IW-1:0] p_sum, d_sum;
  logic [2:0]    p_soft, d_soft;

  logic          is_dealer, is_ace, take, start_ok;
  logic [IW-1:0] card_val, cur_sum, raw_sum, new_sum;
  logic [2:0]    cur_soft, raw_soft, new_soft;

  assign o_PlayerSum = p_sum[SUM_W-1:0];
  assign o_DealerSum = d_sum[SUM_W-1:0];

  always_comb begin
    is_dealer = (state == DEAL_D1) || (state == DEAL_D2) ||
                (state == DEALER);
    is_ace    = (i_Card == 4'd1);
    take      = o_CardReq && i_CardValid;
    start_ok  = i_Start && ((state == IDLE) || (state == DONE));
    card_val  = IW'(10);
    unique case (1'b1)
      is_ace:                             card_val = IW'(11);
      (i_Card >= 4'd2 && i_Card <= 4'd10): card_val = IW'(i_Card);
      default:                            card_val = IW'(10);
    endcase
    cur_sum  = is_dealer ? d_sum : p_sum;
    cur_soft = is_dealer ? d_soft : p_soft;
    raw_sum  = cur_sum + card_val;
    raw_soft = cur_soft + {2'b00, is_ace};
    new_sum  = raw_sum;
    new_soft = raw_soft;
    // One ace demotion per card suffices: only one ace can still count 11.
    if (raw_sum > BJ && raw_soft != 3'd0) begin
      new_sum  = raw_sum - IW'(10);
      new_soft = raw_soft - 3'd1;
    end
    deal_ret = PLAYER;
    unique case (state)
      DEAL_P1: deal_ret = DEAL_D1;
      DEAL_D1: deal_ret = DEAL_P2;
      DEAL_P2: deal_ret = DEAL_D2;
      default: deal_ret = PLAYER;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      p_sum  <= '0;
      d_sum  <= '0;
      p_soft <= '0;
      d_soft <= '0;
    end else if (start_ok) begin
      p_sum  <= '0;
      d_sum  <= '0;
      p_soft <= '0;
      d_soft <= '0;
    end else if (take) begin
      if (is_dealer) begin
        d_sum  <= new_sum;
        d_soft <= new_soft;
      end else begin
        p_sum  <= new_sum;
        p_soft <= new_soft;
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state           <= IDLE;
      ret_state       <= IDLE;
      o_Zero          <= 1'b0;
      o_ActiveCounter <= 1'b0;
      o_CardReq       <= 1'b0;
      o_Result        <= 2'b00;
      o_Busy          <= 1'b0;
      o_Done          <= 1'b0;
    end else begin
      o_Zero <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (i_Start) begin
            o_Result <= 2'b00;
            o_Busy   <= 1'b1;
            o_Done   <= 1'b0;
            state    <= DEAL_P1;
          end
        end
        DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2: begin
          if (!o_CardReq) begin
            o_CardReq <= 1'b1;
          end else if (i_CardValid) begin
            o_CardReq <= 1'b0;
            ret_state <= deal_ret;
            o_Zero    <= 1'b1;
            state     <= WAIT_CLR;
          end
        end
        PLAYER: begin
          if (o_CardReq) begin
            if (i_CardValid) begin
              o_CardReq <= 1'b0;
              ret_state <= (new_sum > BJ) ? RESULT : PLAYER;
              o_Zero    <= 1'b1;
              state     <= WAIT_CLR;
            end
          end else if (p_sum > BJ) begin
            state <= RESULT;
          end else if (p_sum == BJ || i_Stay) begin
            state <= DEALER;
          end else if (i_Hit) begin
            o_CardReq <= 1'b1;
          end
        end
        DEALER: begin
          if (o_CardReq) begin
            if (i_CardValid) begin
              o_CardReq <= 1'b0;
              ret_state <= DEALER;
              o_Zero    <= 1'b1;
              state     <= WAIT_CLR;
            end
          end else if (d_sum < STAND) begin
            o_CardReq <= 1'b1;
          end else begin
            state <= RESULT;
          end
        end
        WAIT_CLR: begin
          o_ActiveCounter <= 1'b1;
          state           <= WAIT_RUN;
        end
        WAIT_RUN: begin
          if (i_TwoSec) begin
            o_ActiveCounter <= 1'b0;
            state           <= ret_state;
          end
        end
        RESULT: begin
          if (p_sum > BJ)      o_Result <= 2'b10;
          else if (d_sum > BJ) o_Result <= 2'b01;
          else if (p_sum > d_sum) o_Result <= 2'b01;
          else if (p_sum < d_sum) o_Result <= 2'b10;
          else                 o_Result <= 2'b11;
          o_Busy <= 1'b0;
          o_Done <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deal_sequencer.sv
// tb_deal_sequencer: scoreboard bench for deal_sequencer.
// Stimulus pushes expected card sums and round results; a monitor pops them.
module tb_deal_sequencer;

  logic       clk_50M = 1'b0;
  logic       i_Reset, i_Start, i_Hit, i_Stay, i_TwoSec, i_CardValid;
  logic [3:0] i_Card;
  logic       o_Zero, o_ActiveCounter, o_CardReq;
  logic [4:0] o_PlayerSum, o_DealerSum;
  logic [1:0] o_Result;
  logic       o_Busy, o_Done;

  deal_sequencer #(.DEALER_STAND(17), .SUM_W(5)) dut (
    .clk_50M(clk_50M), .i_Reset(i_Reset), .i_Start(i_Start),
    .i_Hit(i_Hit), .i_Stay(i_Stay), .i_TwoSec(i_TwoSec),
    .i_CardValid(i_CardValid), .i_Card(i_Card),
    .o_Zero(o_Zero), .o_ActiveCounter(o_ActiveCounter),
    .o_CardReq(o_CardReq), .o_PlayerSum(o_PlayerSum),
    .o_DealerSum(o_DealerSum), .o_Result(o_Result),
    .o_Busy(o_Busy), .o_Done(o_Done)
  );

  always #10 clk_50M = ~clk_50M;

  typedef struct { int p; int d; } card_exp_t;
  typedef struct { int p; int d; int r; int z; int c; } res_exp_t;

  card_exp_t card_exp_q[$];
  res_exp_t  res_q[$];
  int        card_q[$];

  int tests = 0;
  int failed = 0;
  bit tmr_en = 1'b1;
  bit tmr_force = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // card source: answers an open request one cycle later
  initial begin
    i_CardValid = 1'b0;
    i_Card = 4'd0;
    forever begin
      @(posedge clk_50M); #1;
      if (o_CardReq && !i_CardValid && card_q.size() > 0) begin
        i_Card = 4'(card_q.pop_front());
        i_CardValid = 1'b1;
      end else begin
        i_CardValid = 1'b0;
      end
    end
  end

  // timer model: elapsed pulse 5 cycles after enable
  initial begin
    int tcnt;
    tcnt = 0;
    i_TwoSec = 1'b0;
    forever begin
      @(posedge clk_50M); #1;
      i_TwoSec = 1'b0;
      if (tmr_force) begin
        i_TwoSec = 1'b1;
      end else if (o_ActiveCounter && tmr_en) begin
        tcnt++;
        if (tcnt == 5) begin
          i_TwoSec = 1'b1;
          tcnt = 0;
        end
      end else begin
        tcnt = 0;
      end
    end
  end

  // monitor
  initial begin
    bit pend, done_prev;
    int zeros, cards;
    card_exp_t ce;
    res_exp_t re;
    pend = 0; done_prev = 0; zeros = 0; cards = 0;
    forever begin
      @(negedge clk_50M);
      if (i_Reset) begin
        pend = 0; zeros = 0; cards = 0; done_prev = 0;
      end else begin
        if (i_Start) begin
          zeros = 0; cards = 0;
        end
        if (pend) begin
          pend = 0;
          if (card_exp_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL card_sb: card taken with no expectation");
          end else begin
            ce = card_exp_q.pop_front();
            check("card_player_sum", int'(o_PlayerSum), ce.p);
            check("card_dealer_sum", int'(o_DealerSum), ce.d);
          end
        end
        if (o_CardReq && i_CardValid) begin
          pend = 1; cards++;
        end
        if (o_Zero) zeros++;
        if (o_Done && !done_prev) begin
          if (res_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL res_sb: done with no expectation");
          end else begin
            re = res_q.pop_front();
            check("res_player_sum", int'(o_PlayerSum), re.p);
            check("res_dealer_sum", int'(o_DealerSum), re.d);
            check("res_result", int'(o_Result), re.r);
            check("res_zero_pulses", zeros, re.z);
            check("res_cards", cards, re.c);
            check("res_busy", int'(o_Busy), 0);
          end
        end
        done_prev = o_Done;
      end
    end
  end

  task automatic step();
    @(posedge clk_50M); #1;
  endtask

  task automatic pc(input int p, input int d);
    card_exp_t e;
    e.p = p; e.d = d;
    card_exp_q.push_back(e);
  endtask

  task automatic pr(input int p, input int d, input int r,
                    input int z, input int c);
    res_exp_t e;
    e.p = p; e.d = d; e.r = r; e.z = z; e.c = c;
    res_q.push_back(e);
  endtask

  task automatic start_round();
    i_Start = 1'b1;
    step();
    i_Start = 1'b0;
    check("start_busy", int'(o_Busy), 1);
    check("start_result_clr", int'(o_Result), 0);
  endtask

  task automatic press(input bit h, input bit s);
    i_Hit = h; i_Stay = s;
    step();
    i_Hit = 1'b0; i_Stay = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check(name, int'({o_Zero, o_ActiveCounter, o_CardReq,
                      o_PlayerSum, o_DealerSum, o_Result,
                      o_Busy, o_Done}), 0);
  endtask

  task automatic wait_quiet();
    int q, n;
    q = 0; n = 0;
    while (q < 3 && n < 2000) begin
      step(); n++;
      if (!o_CardReq && !o_Zero && !o_ActiveCounter &&
          o_Busy && card_q.size() == 0) q++;
      else q = 0;
    end
    if (q < 3) begin
      tests++; failed++;
      $display("FAIL wait_quiet: timeout after %0d cycles", n);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!o_Done && n < 3000) begin
      step(); n++;
    end
    if (!o_Done) begin
      tests++; failed++;
      $display("FAIL wait_done: timeout, o_Done=%0d expected 1", o_Done);
      i_Reset = 1'b1;
      step();
      i_Reset = 1'b0;
      card_q.delete();
      card_exp_q.delete();
      res_q.delete();
    end
    step(); step();
  endtask

  initial begin
    i_Reset = 1'b1; i_Start = 1'b0; i_Hit = 1'b0; i_Stay = 1'b0;
    repeat (3) step();
    check_idle("reset_state");
    i_Reset = 1'b0;
    step();

    // 10,7,9,10 then stay: 19 vs 17
    card_q = '{10, 7, 9, 10};
    pc(10, 0); pc(10, 7); pc(19, 7); pc(19, 17);
    pr(19, 17, 1, 4, 4);
    start_round();
    wait_quiet();
    press(1'b0, 1'b1);
    wait_done();

    // two aces then hit 9: 11, 12, 21 auto-advance
    card_q = '{1, 10, 1, 8};
    pc(11, 0); pc(11, 10); pc(12, 10); pc(12, 18);
    pc(21, 18);
    pr(21, 18, 1, 5, 5);
    start_round();
    wait_quiet();
    card_q.push_back(9);
    press(1'b1, 1'b0);
    wait_done();
    check("done_result_held", int'(o_Result), 1);
    check("done_flag", int'(o_Done), 1);

    // player bust at 26, dealer must not draw
    card_q = '{10, 9, 6, 5};
    pc(10, 0); pc(10, 9); pc(16, 9); pc(16, 14);
    pc(26, 14);
    pr(26, 14, 2, 5, 5);
    start_round();
    wait_quiet();
    card_q.push_back(10);
    press(1'b1, 1'b0);
    wait_done();
    check("bust_no_req", int'(o_CardReq), 0);

    // dealer soft 17 stands, push
    card_q = '{10, 6, 7, 1};
    pc(10, 0); pc(10, 6); pc(17, 6); pc(17, 17);
    pr(17, 17, 3, 4, 4);
    start_round();
    wait_quiet();
    press(1'b0, 1'b1);
    wait_done();

    // hit+stay together: stay wins, dealer draws 2
    card_q = '{10, 10, 7, 6};
    pc(10, 0); pc(10, 10); pc(17, 10); pc(17, 16);
    pc(17, 18);
    pr(17, 18, 2, 5, 5);
    start_round();
    wait_quiet();
    card_q.push_back(2);
    press(1'b1, 1'b1);
    wait_done();

    // ranks 13, 0, 15 count 10; natural 21 skips input
    card_q = '{13, 0, 1, 15};
    pc(10, 0); pc(10, 10); pc(21, 10); pc(21, 20);
    pr(21, 20, 1, 4, 4);
    start_round();
    wait_done();

    // reset while the timer is running
    tmr_en = 1'b0;
    card_q = '{10};
    pc(10, 0);
    start_round();
    begin
      int n;
      n = 0;
      while (!o_ActiveCounter && n < 200) begin
        step(); n++;
      end
      check("wait_run_active", int'(o_ActiveCounter), 1);
    end
    step();
    i_Reset = 1'b1;
    step();
    i_Reset = 1'b0;
    check_idle("reset_mid_wait");
    step();
    tmr_force = 1'b1;
    step();
    tmr_force = 1'b0;
    repeat (3) step();
    check_idle("twosec_after_reset");
    tmr_en = 1'b1;

    check("card_sb_left", card_exp_q.size(), 0);
    check("res_sb_left", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
